// File: rtl/systolic_pkg.sv
// systolic_pkg: types and defaults shared by data_fetcher, the skew buffer and
// the systolic array.
//   skew_state_t         : skew buffer sequencing states
//   SKEW_MATRIX_SIZE     : default number of lanes (array rows)
//   SKEW_DATA_SIZE       : default width of one lane element
package systolic_pkg;

    localparam int SKEW_MATRIX_SIZE = 2;
    localparam int SKEW_DATA_SIZE   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skew_state_t;

endpackage

// File: rtl/skew_lane.sv
// skew_lane: one delay line of DEPTH registers carrying data and a valid bit,
// plus an optional end-of-matrix tag (TAG=1) that travels with the data.
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   enable    in   1 = shift one stage, 0 = hold every register
//   in_valid  in   load in_data into stage 0 (otherwise a zero bubble is loaded)
//   in_last   in   row being loaded is the last of the matrix
//   in_data   in   lane element
//   out_data  out  last stage data
//   out_valid out  last stage valid
//   out_last  out  last stage tag (constant 0 when TAG=0)
module skew_lane #(
    parameter int DEPTH     = 1,
    parameter int DATA_SIZE = 32,
    parameter bit TAG       = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last
);

    logic [DATA_SIZE-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     last_q;
    logic                 tag_in;

    // Untagged lanes still build the tag chain; it is tied to zero and trimmed.
    assign tag_in = TAG && in_valid && in_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
            last_q  <= '0;
        end else if (enable) begin
            // Bubbles inject zeros so no stale data ever reaches the array.
            data_q[0]  <= in_valid ? in_data : '0;
            valid_q[0] <= in_valid;
            last_q[0]  <= tag_in;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
                last_q[k]  <= last_q[k-1];
            end
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_buffer.sv
// systolic_skew_buffer: delays lane i of each accepted row vector by i cycles to
// form the diagonal wavefront for the systolic array, drains the triangle after
// the last row and pulses done when that row leaves the last lane.
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   enable         in   1 = advance, 0 = freeze all state
//   in_valid       in   in_data / in_last valid
//   in_ready       out  a vector is accepted this cycle if in_valid
//   in_last        in   accepted vector is the last row of the matrix
//   in_data        in   row vector, one element per lane
//   skew_data_out  out  skewed lanes (registered)
//   skew_valid_out out  per-lane valid
//   busy           out  a matrix is streaming or draining
//   done           out  one-cycle pulse as the last row exits lane MATRIX_SIZE-1
//
// state  | meaning
// IDLE   | no matrix in progress
// STREAM | rows of a matrix being accepted, last row not yet seen
// DRAIN  | last row accepted, input held off until it leaves the last lane
module systolic_skew_buffer
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = SKEW_MATRIX_SIZE,
    parameter int DATA_SIZE   = SKEW_DATA_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [DATA_SIZE-1:0]   in_data        [MATRIX_SIZE-1:0],
    output logic [DATA_SIZE-1:0]   skew_data_out  [MATRIX_SIZE-1:0],
    output logic [MATRIX_SIZE-1:0] skew_valid_out,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = $clog2(MATRIX_SIZE) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MATRIX_SIZE - 1);

    skew_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic [MATRIX_SIZE-1:0] lane_last;

    assign in_ready = enable && (state_q != DRAIN);
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        skew_lane #(
            .DEPTH     (i + 1),
            .DATA_SIZE (DATA_SIZE),
            .TAG       (i == MATRIX_SIZE - 1)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .in_valid  (accept),
            .in_last   (in_last),
            .in_data   (in_data[i]),
            .out_data  (skew_data_out[i]),
            .out_valid (skew_valid_out[i]),
            .out_last  (lane_last[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (enable) begin
            case (state_q)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (!in_last) begin
                            state_d = STREAM;
                        end else if (MATRIX_SIZE == 1) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DRAIN;
                            cnt_d   = '0;
                        end
                    end
                end
                DRAIN: begin
                    // Leave as the count reaches MATRIX_SIZE-1: the tagged row is
                    // then in the last lane's output register and input may resume.
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q + CW'(1) == CNT_LAST) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

    // Only the last lane carries a tag; the others are constant zero.
    assign done = enable && (|lane_last);

endmodule

// File: tb/tb_systolic_skew_buffer.sv
module tb_systolic_skew_buffer;

    localparam int M = 3;
    localparam int D = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [D-1:0]  in_data        [M-1:0];
    logic [D-1:0]  skew_data_out  [M-1:0];
    logic [M-1:0]  skew_valid_out;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    // Reference model: history of the row vectors seen at each enabled edge,
    // entry 0 = most recent. Lane i shows lane i of the entry i edges old.
    logic [D-1:0] m_vec [M][M];
    logic         m_v   [M];
    logic         m_l   [M];
    logic         m_in_matrix;
    logic         m_en;

    systolic_skew_buffer #(.MATRIX_SIZE(M), .DATA_SIZE(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_last        (in_last),
        .in_data        (in_data),
        .skew_data_out  (skew_data_out),
        .skew_valid_out (skew_valid_out),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    wire [3*D+M+2:0] dut_vec = {skew_data_out[2], skew_data_out[1], skew_data_out[0],
                                skew_valid_out, done, in_ready, busy};

    function automatic logic m_draining();
        logic r = 1'b0;
        for (int k = 0; k < M - 1; k++) r |= (m_v[k] && m_l[k]);
        return r;
    endfunction

    function automatic logic [3*D+M+2:0] exp_vec();
        logic [M-1:0] ev;
        logic ed, er, eb;
        for (int i = 0; i < M; i++) ev[i] = m_v[i];
        ed = m_en && m_v[M-1] && m_l[M-1];
        er = m_en && !m_draining();
        eb = m_in_matrix || m_draining();
        return {m_vec[2][2], m_vec[1][1], m_vec[0][0], ev, ed, er, eb};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < M; k++) begin
            for (int j = 0; j < M; j++) m_vec[k][j] = '0;
            m_v[k] = 1'b0;
            m_l[k] = 1'b0;
        end
        m_in_matrix = 1'b0;
    endtask

    // One clock: drive inputs, advance the model at the edge, return #1 after it.
    task automatic step(input logic en, input logic v, input logic last,
                        input logic [D-1:0] a0, input logic [D-1:0] a1, input logic [D-1:0] a2);
        logic acc;
        enable = en; in_valid = v; in_last = last;
        in_data[0] = a0; in_data[1] = a1; in_data[2] = a2;
        acc = en && v && !m_draining();
        @(posedge clk);
        if (en) begin
            for (int k = M - 1; k > 0; k--) begin
                for (int j = 0; j < M; j++) m_vec[k][j] = m_vec[k-1][j];
                m_v[k] = m_v[k-1];
                m_l[k] = m_l[k-1];
            end
            m_vec[0][0] = acc ? a0 : '0;
            m_vec[0][1] = acc ? a1 : '0;
            m_vec[0][2] = acc ? a2 : '0;
            m_v[0] = acc;
            m_l[0] = acc && last;
        end
        if (acc) m_in_matrix = !last;
        m_en = en;
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 0, 32'hA1, 32'hA2, 32'hA3);
        step(1, 1, 0, 32'hB1, 32'hB2, 32'hB3);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dut_vec !== {{3*D{1'b0}}, 3'b000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_assert: got %h expected %h", dut_vec,
                     {{3*D{1'b0}}, 3'b000, 1'b0, 1'b1, 1'b0});
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        m_en = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", in_ready, busy);
        end
    endtask

    task automatic test_single_row();
        for (int c = 0; c < 4; c++) begin
            step(1, c == 0, c == 0, 32'h11, 32'h22, 32'h33);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL single_row_model cyc%0d: got %h expected %h", c + 1, dut_vec, exp_vec());
            end
            checks++;
            case (c)
                0: if (skew_data_out[0] !== 32'h11 || skew_valid_out !== 3'b001 || in_ready !== 1'b0 || done !== 1'b0) begin
                       errors++;
                       $display("FAIL single_row cyc1: got lane0=%h valid=%b ready=%b done=%b expected 11 001 0 0",
                                skew_data_out[0], skew_valid_out, in_ready, done);
                   end
                1: if (skew_data_out[1] !== 32'h22 || skew_valid_out !== 3'b010 || in_ready !== 1'b0 || done !== 1'b0) begin
                       errors++;
                       $display("FAIL single_row cyc2: got lane1=%h valid=%b ready=%b done=%b expected 22 010 0 0",
                                skew_data_out[1], skew_valid_out, in_ready, done);
                   end
                2: if (skew_data_out[2] !== 32'h33 || skew_valid_out !== 3'b100 || done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
                       errors++;
                       $display("FAIL single_row cyc3: got lane2=%h valid=%b done=%b ready=%b busy=%b expected 33 100 1 1 0",
                                skew_data_out[2], skew_valid_out, done, in_ready, busy);
                   end
                default: if (done !== 1'b0 || skew_valid_out !== 3'b000) begin
                       errors++;
                       $display("FAIL single_row cyc4: got done=%b valid=%b expected 0 000", done, skew_valid_out);
                   end
            endcase
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            step(1, c < 3, c == 2, 32'h100 + c * 16 + 0, 32'h100 + c * 16 + 1, 32'h100 + c * 16 + 2);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back_model cyc%0d: got %h expected %h", c + 1, dut_vec, exp_vec());
            end
            checks++;
            if (done !== (c == 4)) begin
                errors++;
                $display("FAIL back_to_back_done cyc%0d: got %b expected %b", c + 1, done, c == 4);
            end
            if (c == 2) begin
                checks++;
                if (skew_data_out[0] !== 32'h120 || skew_data_out[1] !== 32'h111 || skew_data_out[2] !== 32'h102) begin
                    errors++;
                    $display("FAIL back_to_back_wavefront: got %h %h %h expected 120 111 102",
                             skew_data_out[0], skew_data_out[1], skew_data_out[2]);
                end
            end
        end
    endtask

    task automatic test_bubble();
        for (int c = 0; c < 6; c++) begin
            step(1, c != 1 && c < 3, c == 2, 32'hC0 + c, 32'hD0 + c, 32'hE0 + c);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL bubble_model cyc%0d: got %h expected %h", c + 1, dut_vec, exp_vec());
            end
            for (int i = 0; i < M; i++) begin
                if (c == 1 + i) begin
                    checks++;
                    if (skew_data_out[i] !== 32'h0 || skew_valid_out[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL bubble_lane%0d: got data=%h valid=%b expected 0 0",
                                 i, skew_data_out[i], skew_valid_out[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_freeze_drain();
        for (int c = 0; c < 6; c++) begin
            step(c != 1 && c != 2, c == 0, c == 0, 32'h51, 32'h52, 32'h53);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL freeze_model cyc%0d: got %h expected %h", c + 1, dut_vec, exp_vec());
            end
            checks++;
            if (done !== (c == 4)) begin
                errors++;
                $display("FAIL freeze_done cyc%0d: got %b expected %b", c + 1, done, c == 4);
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (skew_data_out[0] !== 32'h51 || skew_valid_out !== 3'b001 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL freeze_hold cyc%0d: got lane0=%h valid=%b ready=%b expected 51 001 0",
                             c + 1, skew_data_out[0], skew_valid_out, in_ready);
                end
            end
            if (c == 4) begin
                enable = 1'b0;
                #1;
                checks++;
                if (done !== 1'b0 || skew_data_out[2] !== 32'h53) begin
                    errors++;
                    $display("FAIL freeze_done_forced: got done=%b lane2=%h expected 0 53", done, skew_data_out[2]);
                end
                enable = 1'b1;
                #1;
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL freeze_done_resume: got done=%b expected 1", done);
                end
            end
        end
    endtask

    task automatic test_last_without_valid();
        for (int c = 0; c < 8; c++) begin
            step(1, c == 0 || c == 4, c != 0, 32'h71 + c, 32'h81 + c, 32'h91 + c);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL last_no_valid_model cyc%0d: got %h expected %h", c + 1, dut_vec, exp_vec());
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL last_no_valid cyc%0d: got busy=%b done=%b ready=%b expected 1 0 1",
                             c + 1, busy, done, in_ready);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 6) == 0,
                 $urandom, $urandom, $urandom);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d: got %h expected %h", c, dut_vec, exp_vec());
            end
        end
        for (int c = 0; c < M + 2; c++) begin
            step(1, 0, 0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_flush cyc%0d: got %h expected %h", c, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        for (int i = 0; i < M; i++) in_data[i] = '0;
        model_clear();
        m_en = 1'b0;
        #2;
        checks++;
        if (dut_vec !== {{3*D{1'b0}}, 3'b000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected all zero", dut_vec);
        end
        enable = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_follows_enable: got %b expected 1", in_ready);
        end
        #9;
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_en = 1'b1;

        test_single_row();
        test_back_to_back();
        test_bubble();
        test_freeze_drain();
        test_last_without_valid();
        test_reset();
        test_random();
        test_reset();
        test_single_row();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
